bcd_convert_sequencer: RTL
==========================

// Module: bcd_convert_sequencer
// PURPOSE
//  Multi-cycle signed binary to sign+BCD converter. Captures a WIDTH-bit two's-complement
//  operand on a start pulse and takes its magnitude. It then runs a shift-and-add-3
//  (double-dabble) sequence, one bit per clock. Result is DIGITS packed BCD digits plus a
//  sign bit. Serial, wider-operand successor to the combinational 5-bit BCD transfer.
//  Sits between operand source and 7-seg/display logic.
// PARAMETERS
//  WIDTH   8  operand width, two's complement, >=2
//  DIGITS  3  BCD output digits; must satisfy 10**DIGITS > 2**(WIDTH-1)
//  CNTW    4  shift-counter width; must satisfy 2**CNTW > WIDTH
// PORTS
//  clk    in   1           rising-edge clock
//  rst    in   1           asynchronous, active-high reset
//  start  in   1           request conversion; sampled only when busy==0
//  in     in   WIDTH       signed operand, captured on accepted start
//  busy   out  1           conversion in progress; start ignored while high
//  done   out  1           one-cycle pulse: out holds a new result
//  out    out  4*DIGITS+1  {sign, digit[DIGITS-1]..digit[0]}, digit[0] = units
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, busy=0, done=0, out=0, internal regs=0.
//  FSM states (registered): IDLE, ABS, SHIFT, DONE.
//   IDLE : start=1 -> latch in, sign=in[WIDTH-1]; go ABS. start=0 -> stay.
//   ABS  : mag = sign ? (~in_q + 1) : in_q, WIDTH-bit unsigned. Min value -2**(WIDTH-1)
//          gives mag=2**(WIDTH-1) without overflow. Clear BCD regs, cnt=0; go SHIFT.
//   SHIFT: each cycle, add 3 to every BCD digit >=5 (all digits in parallel).
//          Then shift {bcd,mag} left by 1; mag MSB enters digit[0] LSB; cnt++.
//          After the WIDTH-th shift: out<={sign_adj,bcd}, done<=1; go DONE.
//   DONE : done=1 for exactly this cycle. start=1 -> accepted as in IDLE, go ABS.
//          Else go IDLE.
//  busy = 1 in ABS and SHIFT, 0 in IDLE and DONE (back-to-back accepted from DONE).
//  Latency: start sampled at edge k -> out/done update at edge k+WIDTH+1. done is high
//   for cycle k+WIDTH+1..k+WIDTH+2. Back-to-back throughput: one result per WIDTH+2 clk.
//  sign_adj = sign & (mag!=0). Negative zero is impossible; out is never -0.
//  out holds last result until next done. Only update: edge where done rises. Never
//   shows partial values.
//  start while busy: ignored, not queued. Changes on in after capture: no effect.
//  start held high continuously: a new conversion is accepted every WIDTH+2 cycles.
//  Digit add-3 is 4-bit modulo; no digit ever exceeds 9 at output for legal parameters.
//  Reset mid-conversion: aborts; no done pulse; out=0; next start begins cleanly.
// TESTING
//  T1 in=8'h2D (+45), pulse start -> busy 1 for 9 cycles; done at edge k+9; out=13'h0045.
//  T2 in=8'h80 (-128) -> out=13'h1128; in=8'hFF (-1) -> out=13'h1001; in=8'h7F -> 13'h0127.
//  T3 in=8'h00 -> out=13'h0000 (sign 0); in=8'hF6 (-10) -> out=13'h1010.
//  T4 start held high, in=+99 then -99 at accept edges -> done every 10 cycles.
//   out=13'h0099 then 13'h1099; start pulses during busy -> ignored, no extra done.
//  T5 assert rst at SHIFT cycle 4 of in=+77 -> busy,done,out=0 immediately, no done.
//   Restart with +77 -> out=13'h0077.
//  T6 sweep all 256 operands vs reference model (sign, |x| decimal digits); zero mismatch.

Source files
------------

// File: rtl/bcd_convert_sequencer.sv
// Serial signed-binary to sign+packed-BCD converter (double-dabble, one bit per clock).
// Result and done are registered; out only changes on the edge that raises done.
module bcd_convert_sequencer #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int CNTW   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS:0]   out
);

  typedef enum logic [1:0] {IDLE, ABS, SHIFT, DONE} state_t;

  state_t              state;
  logic [WIDTH-1:0]    in_q;
  logic [WIDTH-1:0]    mag;
  logic                sign_q;
  logic [4*DIGITS-1:0] bcd;
  logic [CNTW-1:0]     cnt;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [4*DIGITS-1:0] bcd_shift;

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5)
        bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[4*DIGITS-2:0], mag[WIDTH-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      in_q   <= '0;
      mag    <= '0;
      sign_q <= 1'b0;
      bcd    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      out    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            in_q   <= in;
            sign_q <= in[WIDTH-1];
            busy   <= 1'b1;
            state  <= ABS;
          end else begin
            state <= IDLE;
          end
        end
        ABS: begin
          mag    <= sign_q ? (~in_q + 1'b1) : in_q;
          // a zero operand never yields a negative sign
          sign_q <= sign_q & (in_q != '0);
          bcd    <= '0;
          cnt    <= '0;
          state  <= SHIFT;
        end
        SHIFT: begin
          bcd <= bcd_shift;
          mag <= {mag[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CNTW'(WIDTH-1)) begin
            out   <= {sign_q, bcd_shift};
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
